// File: rtl/audio_playback_ctrl_pkg.sv
// Shared types and constants for the audio playback sequencer.
// Holds the FSM encoding, word/sample layout and region bound.
package audio_playback_ctrl_pkg;

  localparam int          WORD_W          = 32;
  localparam int          SAMPLE_BYTE_MSB = 15;
  localparam int          SAMPLE_BYTE_LSB = 8;
  localparam logic [22:0] ADDR_MAX_DEF    = 23'h7FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_WAIT_T0,
    ST_WAIT_T1,
    ST_NEXT
  } state_t;

  // Upper byte of a signed 16-bit sample drives the 8-bit output.
  function automatic logic [7:0] sample_byte(input logic [15:0] s);
    return s[SAMPLE_BYTE_MSB:SAMPLE_BYTE_LSB];
  endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// Free-running sample-rate tick: one pulse every clk_div+1 cycles.
// Tick is registered, so a divider drop below the count fires next cycle.
module audio_tick_gen
  import audio_playback_ctrl_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;
  logic             r_tick;
  logic             w_hit;

  assign w_hit = (r_count >= clk_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= w_hit;
      r_count <= w_hit ? '0 : r_count + DIV_W'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/audio_playback_ctrl.sv
// Flash-backed audio sample sequencer: fetches 32-bit words and
// emits their two sample bytes forward or backward on a rate tick.
module audio_playback_ctrl
  import audio_playback_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(ADDR_MAX_DEF),
  parameter int                DIV_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              dir_fwd,
  input  logic              restart,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [WORD_W-1:0] flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [7:0]        audio_data,
  output logic              audio_valid,
  output logic              addr_wrap
);

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [WORD_W-1:0]   r_word, w_word;
  logic                r_fwd, w_fwd;
  logic                r_pend, w_pend;
  logic [7:0]          r_audio, w_audio;
  logic                r_valid, w_valid;
  logic                r_wrap, w_wrap;
  logic                w_tick;
  logic                w_go;
  logic [ADDR_W-1:0]   w_rst_addr;
  logic [15:0]         w_first, w_second;

  audio_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clk_div (clk_div),
    .tick    (w_tick)
  );

  assign w_go       = w_tick & play;
  assign w_rst_addr = dir_fwd ? '0 : ADDR_MAX;
  assign w_first    = r_fwd ? r_word[15:0]  : r_word[31:16];
  assign w_second   = r_fwd ? r_word[31:16] : r_word[15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_word  <= '0;
      r_fwd   <= 1'b1;
      r_pend  <= 1'b0;
      r_audio <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_word  <= w_word;
      r_fwd   <= w_fwd;
      r_pend  <= w_pend;
      r_audio <= w_audio;
      r_valid <= w_valid;
      r_wrap  <= w_wrap;
    end
  end

  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_word  = r_word;
    w_fwd   = r_fwd;
    w_pend  = r_pend;
    w_audio = r_audio;
    w_valid = 1'b0;
    w_wrap  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (restart) begin
          w_addr = w_rst_addr;
        end else if (play) begin
          w_state = ST_REQ;
        end
      end
      ST_REQ: begin
        // A read in flight is never abandoned; restart waits for the data.
        if (restart) w_pend = 1'b1;
        if (!flash_waitrequest) w_state = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (flash_readdatavalid) begin
          if (r_pend || restart) begin
            w_addr  = w_rst_addr;
            w_pend  = 1'b0;
            w_state = ST_IDLE;
          end else begin
            w_word  = flash_readdata;
            w_fwd   = dir_fwd;
            w_state = ST_WAIT_T0;
          end
        end else if (restart) begin
          w_pend = 1'b1;
        end
      end
      ST_WAIT_T0: begin
        if (restart) begin
          w_addr  = w_rst_addr;
          w_state = ST_IDLE;
        end else if (w_go) begin
          w_audio = sample_byte(w_first);
          w_valid = 1'b1;
          w_state = ST_WAIT_T1;
        end
      end
      ST_WAIT_T1: begin
        if (restart) begin
          w_addr  = w_rst_addr;
          w_state = ST_IDLE;
        end else if (w_go) begin
          w_audio = sample_byte(w_second);
          w_valid = 1'b1;
          w_state = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (restart) begin
          w_addr  = w_rst_addr;
          w_state = ST_IDLE;
        end else begin
          if (dir_fwd) begin
            if (r_addr >= ADDR_MAX) begin
              w_addr = '0;
              w_wrap = 1'b1;
            end else begin
              w_addr = r_addr + ADDR_W'(1);
            end
          end else begin
            if (r_addr == '0) begin
              w_addr = ADDR_MAX;
              w_wrap = 1'b1;
            end else begin
              w_addr = r_addr - ADDR_W'(1);
            end
          end
          w_state = play ? ST_REQ : ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign flash_read    = (r_state == ST_REQ);
  assign flash_address = r_addr;
  assign audio_data    = r_audio;
  assign audio_valid   = r_valid;
  assign addr_wrap     = r_wrap;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Bench for audio_playback_ctrl: flash responder, sample scoreboard,
// directed scenarios and a randomized run against a behavioural model.
module tb_audio_playback_ctrl;

  localparam int          AW   = 23;
  localparam logic [22:0] AMAX = 23'h7FFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          play;
  logic          dir_fwd;
  logic          restart;
  logic [31:0]   clk_div;
  logic          flash_read;
  logic [AW-1:0] flash_address;
  logic          flash_waitrequest;
  logic [31:0]   flash_readdata;
  logic          flash_readdatavalid;
  logic [7:0]    audio_data;
  logic          audio_valid;
  logic          addr_wrap;

  audio_playback_ctrl #(
    .ADDR_W   (AW),
    .ADDR_MAX (AMAX),
    .DIV_W    (32)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .play                (play),
    .dir_fwd             (dir_fwd),
    .restart             (restart),
    .clk_div             (clk_div),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .audio_data          (audio_data),
    .audio_valid         (audio_valid),
    .addr_wrap           (addr_wrap)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // bench-side records
  int            cyc = 0;
  int            n_strobe = 0;
  int            strobe_cyc[$];
  logic [7:0]    strobe_dat[$];
  int            n_acc = 0;
  logic [AW-1:0] acc_addr[$];
  int            wrap_cnt = 0;
  int            n_rdv = 0;

  // flash responder configuration
  int            cfg_stall = 0;
  int            cfg_lat   = 0;
  bit            cfg_rand  = 1'b0;
  bit            cfg_fixed = 1'b1;
  logic [31:0]   cfg_word  = 32'hAABB_CCDD;

  // reference model state
  logic [7:0]    exp_q[$];
  bit            m_abs = 1'b1;
  logic [AW-1:0] m_abs_addr = '0;
  logic [AW-1:0] m_prev = '0;
  int            m_wrap_base = 0;
  bit            m_discard = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Region walk as plain integer arithmetic with wrap at both ends.
  function automatic int next_addr(input logic [AW-1:0] a, input logic fwd);
    int n;
    n = fwd ? int'(a) + 1 : int'(a) - 1;
    if (n > int'(AMAX)) n = 0;
    if (n < 0) n = int'(AMAX);
    return n;
  endfunction

  function automatic int wraps(input logic [AW-1:0] a, input logic fwd);
    return (fwd && a == AMAX) || (!fwd && a == '0) ? 1 : 0;
  endfunction

  // Flash slave plus scoreboard, evaluated 1 time unit after each edge.
  initial begin : mon
    bit            prev_read;
    bit            prev_wait;
    logic [AW-1:0] prev_addr;
    int            stall_left;
    bit            cd_act;
    int            cd;
    bit            rdv_prev;
    logic [31:0]   rdv_word;
    int            exp_a;
    int            exp_w;
    bit            have;
    prev_read = 0; prev_wait = 0; prev_addr = '0;
    stall_left = 0; cd_act = 0; cd = 0; rdv_prev = 0; rdv_word = '0;
    flash_waitrequest   = 1'b0;
    flash_readdatavalid = 1'b0;
    flash_readdata      = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        flash_waitrequest   = 1'b0;
        flash_readdatavalid = 1'b0;
        prev_read = 0; prev_wait = 0; cd_act = 0; rdv_prev = 0;
        exp_q.delete();
        m_abs = 1'b1; m_abs_addr = '0; m_discard = 1'b0;
        m_wrap_base = wrap_cnt;
      end else begin
        if (rdv_prev) begin
          rdv_prev = 0;
          n_rdv++;
          if (m_discard) begin
            m_discard = 1'b0;
          end else if (dir_fwd) begin
            exp_q.push_back(rdv_word[15:8]);
            exp_q.push_back(rdv_word[31:24]);
          end else begin
            exp_q.push_back(rdv_word[31:24]);
            exp_q.push_back(rdv_word[15:8]);
          end
        end
        if (addr_wrap) wrap_cnt++;
        if (audio_valid) begin
          n_strobe++;
          strobe_cyc.push_back(cyc);
          strobe_dat.push_back(audio_data);
          have = exp_q.size() != 0;
          chk("strobe_has_sample", 32'(have), 32'd1);
          if (have) chk("audio_data", 32'(audio_data), 32'(exp_q.pop_front()));
        end
        if (prev_read && !prev_wait) begin
          n_acc++;
          acc_addr.push_back(prev_addr);
          if (m_abs) begin
            exp_a = int'(m_abs_addr);
            exp_w = 0;
          end else begin
            exp_a = next_addr(m_prev, dir_fwd);
            exp_w = wraps(m_prev, dir_fwd);
          end
          chk("read_addr", 32'(prev_addr), 32'(exp_a));
          chk("wrap_pulses", 32'(wrap_cnt - m_wrap_base), 32'(exp_w));
          m_abs = 1'b0;
          m_prev = prev_addr;
          m_wrap_base = wrap_cnt;
          cd_act = 1;
          cd = cfg_rand ? int'($urandom_range(0, 3)) : cfg_lat;
        end
        flash_readdatavalid = 1'b0;
        if (cd_act) begin
          if (cd == 0) begin
            flash_readdatavalid = 1'b1;
            flash_readdata = cfg_fixed ? cfg_word : $urandom();
            rdv_word = flash_readdata;
            rdv_prev = 1;
            cd_act = 0;
          end else begin
            cd--;
          end
        end
        if (flash_read && !prev_read)
          stall_left = cfg_rand ? int'($urandom_range(0, 3)) : cfg_stall;
        flash_waitrequest = flash_read && (stall_left > 0);
        if (flash_waitrequest) stall_left--;
        prev_read = flash_read;
        prev_wait = flash_waitrequest;
        prev_addr = flash_address;
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic wait_strobes(input int target, input int budget,
                              input string tag);
    int k = 0;
    while (n_strobe < target && k < budget) begin
      @(posedge clk); #3; k++;
    end
    chk(tag, 32'(n_strobe), 32'(target));
  endtask

  task automatic wait_acc(input int target, input int budget,
                          input string tag);
    int k = 0;
    while (n_acc < target && k < budget) begin
      @(posedge clk); #3; k++;
    end
    chk(tag, 32'(n_acc), 32'(target));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc_wait(2);
    n_strobe = 0; strobe_cyc.delete(); strobe_dat.delete();
    n_acc = 0; acc_addr.delete();
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: run exceeded time limit (%0d/%0d so far)",
             n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s0;
    int w0;
    int k;
    int last_rdv;
    reset = 1'b1; play = 1'b0; dir_fwd = 1'b1; restart = 1'b0;
    clk_div = 32'd3;
    cfg_stall = 2; cfg_lat = 2;

    // reset values
    cyc_wait(2);
    chk("rst_read", 32'(flash_read), 32'd0);
    chk("rst_addr", 32'(flash_address), 32'd0);
    chk("rst_data", 32'(audio_data), 32'd0);
    chk("rst_valid", 32'(audio_valid), 32'd0);
    chk("rst_wrap", 32'(addr_wrap), 32'd0);

    // forward word: low sample first, strobes one tick period apart
    do_reset();
    play = 1'b1;
    wait_strobes(2, 100, "fwd_strobes");
    chk("fwd_s0", 32'(strobe_dat[0]), 32'hCC);
    chk("fwd_s1", 32'(strobe_dat[1]), 32'hAA);
    chk("fwd_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd4);
    wait_acc(2, 60, "fwd_next_read");
    chk("fwd_next_addr", 32'(acc_addr[1]), 32'd1);

    // backward from 0 wraps to the top of the region
    dir_fwd = 1'b0;
    do_reset();
    w0 = wrap_cnt;
    wait_strobes(2, 100, "bwd_strobes");
    chk("bwd_s0", 32'(strobe_dat[0]), 32'hAA);
    chk("bwd_s1", 32'(strobe_dat[1]), 32'hCC);
    wait_acc(2, 60, "bwd_next_read");
    chk("bwd_next_addr", 32'(acc_addr[1]), 32'(AMAX));
    chk("bwd_wrap", 32'(wrap_cnt - w0), 32'd1);

    // switch to forward before the word at the top arrives
    dir_fwd = 1'b1;
    wait_strobes(4, 100, "top_strobes");
    chk("top_s0", 32'(strobe_dat[2]), 32'hCC);
    chk("top_s1", 32'(strobe_dat[3]), 32'hAA);
    wait_acc(3, 60, "top_next_read");
    chk("top_next_addr", 32'(acc_addr[2]), 32'd0);
    chk("top_wrap", 32'(wrap_cnt - w0), 32'd2);

    // pause between the two samples of a word
    wait_strobes(5, 100, "pause_first");
    play = 1'b0;
    cyc_wait(20);
    chk("pause_silent", 32'(n_strobe), 32'd5);
    play = 1'b1;
    wait_strobes(6, 5, "resume_next_tick");
    chk("resume_data", 32'(strobe_dat[5]), 32'hAA);

    // asynchronous reset while a read is stalled
    cfg_stall = 1000;
    k = 0;
    while (!flash_read && k < 40) begin cyc_wait(1); k++; end
    cyc_wait(3);
    chk("req_stalled", 32'(flash_read), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_read", 32'(flash_read), 32'd0);
    chk("arst_addr", 32'(flash_address), 32'd0);
    chk("arst_valid", 32'(audio_valid), 32'd0);
    cyc_wait(2);
    cfg_stall = 0;
    do_reset();
    wait_acc(1, 40, "arst_reread");
    chk("arst_reread_addr", 32'(acc_addr[0]), 32'd0);

    // restart during WAIT_DATA at address 5
    clk_div = 32'd1;
    do_reset();
    wait_acc(6, 400, "rs_reach5");
    chk("rs_addr5", 32'(acc_addr[5]), 32'd5);
    restart = 1'b1;
    m_discard = 1'b1; m_abs = 1'b1; m_abs_addr = '0;
    s0 = n_strobe;
    cyc_wait(1);
    restart = 1'b0;
    wait_acc(7, 60, "rs_reread");
    chk("rs_reread_addr", 32'(acc_addr[6]), 32'd0);
    chk("rs_no_strobe", 32'(n_strobe), 32'(s0));

    // divider drop below the running count
    cfg_stall = 0; cfg_lat = 0;
    clk_div = 32'd7;
    do_reset();
    wait_strobes(1, 60, "div_first");
    cyc_wait(4);
    clk_div = 32'd1;
    wait_strobes(4, 60, "div_after");
    chk("div_drop_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd6);
    chk("div_fast_gap", 32'(strobe_cyc[3] - strobe_cyc[2]), 32'd2);

    // randomized run against the model
    cfg_rand = 1'b1; cfg_fixed = 1'b0;
    clk_div = 32'd0;
    dir_fwd = 1'($urandom_range(0, 1));
    do_reset();
    last_rdv = n_rdv;
    for (int i = 0; i < 3000; i++) begin
      cyc_wait(1);
      if (n_rdv != last_rdv) begin
        last_rdv = n_rdv;
        if ($urandom_range(0, 3) == 0) dir_fwd = ~dir_fwd;
      end
      if ($urandom_range(0, 49) == 0) play = ~play;
      if ($urandom_range(0, 99) == 0) clk_div = $urandom_range(0, 5);
    end
    chk("rand_progress", 32'(n_strobe > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
